// File: rtl/cloud_ctrl_pkg.sv
// Shared types and constants for the cloud run controller.
//   ctrl_state_e : controller state encoding
//   SIG_W        : signature width
//   MISR_POLY    : MISR feedback polynomial
//   SIG_INIT     : signature value loaded when a run is accepted
//   misr_step()  : one MISR update step
package cloud_ctrl_pkg;

    localparam int unsigned SIG_W = 32;
    localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [SIG_W-1:0] SIG_INIT  = '0;

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StRun,
        StDone
    } ctrl_state_e;

    // Shift left, fold the bit shifted out back through the polynomial, then
    // inject the two cloud outputs into the low bits.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [1:0]       din);
        logic [SIG_W-1:0] nxt;
        nxt = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            nxt = nxt ^ MISR_POLY;
        end
        nxt = nxt ^ {{(SIG_W-2){1'b0}}, din};
        return nxt;
    endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load SIG_INIT (has priority over en)
//   en         : compact din into the signature this cycle
//   din[1:0]   : {right cloud output, left cloud output}
//   sig[31:0]  : registered signature
module misr32
    import cloud_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = SIG_INIT;
        end else if (en) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SIG_INIT;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/cloud_run_ctrl.sv
// Run controller for a left/right pair of logic clouds: seeds the left cloud,
// free-runs both for run_len cycles and compacts their outputs into a MISR.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : run request / termination from the test harness
//   run_len[LEN_W-1:0]    : RUN cycle count, latched when start is accepted
//   left_out, right_out   : cloud outputs compacted during RUN
//   cloud_en, cloud_seed  : cloud clock enable and left-cloud seed input
//   busy, done, aborted   : status (done/aborted are one-cycle pulses)
//   signature[31:0]       : MISR result, stable from done until next start
// All outputs are registered from the next-state decode.
module cloud_run_ctrl
    import cloud_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned SEED_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] run_len,
    input  logic             left_out,
    input  logic             right_out,
    output logic             cloud_en,
    output logic             cloud_seed,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [SIG_W-1:0] signature
);

    localparam logic [7:0]       SeedLast = 8'(SEED_CYCLES - 1);
    localparam logic [LEN_W-1:0] LenOne   = LEN_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [7:0]       seed_cnt_q, seed_cnt_d;
    logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             cloud_en_q, cloud_en_d;
    logic             cloud_seed_q, cloud_seed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             misr_clr, misr_en;

    always_comb begin
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        run_cnt_d  = run_cnt_q;
        len_d      = len_q;
        aborted_d  = 1'b0;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort is ignored here, so start+abort together starts a run
                if (start) begin
                    state_d    = StSeed;
                    len_d      = run_len;
                    seed_cnt_d = '0;
                    misr_clr   = 1'b1;
                end
            end
            StSeed: begin
                if (abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (seed_cnt_q == SeedLast) begin
                    run_cnt_d = '0;
                    state_d   = (len_q == '0) ? StDone : StRun;
                end else begin
                    seed_cnt_d = seed_cnt_q + 8'd1;
                end
            end
            StRun: begin
                misr_en = 1'b1;
                if (abort) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (run_cnt_q == len_q - LenOne) begin
                    // compare against len-1 so the counter never wraps at max length
                    state_d = StDone;
                end else begin
                    run_cnt_d = run_cnt_q + LenOne;
                end
            end
            StDone: begin
                state_d   = StIdle;
                aborted_d = abort;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cloud_en_d   = (state_d == StSeed) || (state_d == StRun);
        cloud_seed_d = (state_d == StSeed);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            seed_cnt_q   <= '0;
            run_cnt_q    <= '0;
            len_q        <= '0;
            cloud_en_q   <= 1'b0;
            cloud_seed_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_cnt_q   <= seed_cnt_d;
            run_cnt_q    <= run_cnt_d;
            len_q        <= len_d;
            cloud_en_q   <= cloud_en_d;
            cloud_seed_q <= cloud_seed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    misr32 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   ({right_out, left_out}),
        .sig   (signature)
    );

    assign cloud_en   = cloud_en_q;
    assign cloud_seed = cloud_seed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: doc/cloud_run_ctrl.md
# cloud_run_ctrl

Run controller for a pair of placed logic clouds (left cloud feeding right cloud across the die). On a start request it gates both clouds on, seeds the left cloud for a fixed number of cycles, then free-runs them for a programmable number of cycles. While running it compacts both cloud outputs into a 32-bit MISR signature and reports completion. It sits between the top-level test harness (start/abort, result readout) and the two cloud instances (enable, seed, outputs).

## Interface
Parameters:
- `LEN_W`, 16: width of `run_len`.
- `SEED_CYCLES`, 4: cycles the seed is held high before running; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `abort`  in  1  terminate the current run; sampled only when not IDLE.
- `run_len`  in  LEN_W  number of RUN cycles; latched when `start` is accepted.
- `left_out`  in  1  left cloud output.
- `right_out`  in  1  right cloud output, the cross-die path.
- `cloud_en`  out  1  clock enable to both clouds.
- `cloud_seed`  out  1  drives the left cloud `in_signal`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `aborted`  out  1  one-cycle pulse when an abort is taken.
- `signature`  out  32  MISR result; stable from `done` until the next accepted start.

## Operation
- States:
  - IDLE: the only state `start` is sampled in. `start=1` → SEED; it latches `run_len`, clears the seed counter and loads `signature` with `SIG_INIT` (0).
  - SEED: `cloud_en=1`, `cloud_seed=1` for exactly `SEED_CYCLES` cycles. It then goes to RUN, or straight to DONE if the latched length is 0.
  - RUN: `cloud_en=1`, `cloud_seed=0`. The MISR updates on every RUN cycle. Exits to DONE after exactly the latched `run_len` cycles.
  - DONE: `done=1`, `cloud_en=0`, `cloud_seed=0`; one cycle, then → IDLE.
- MISR update, evaluated at the end of each RUN cycle:
  - `sig_next = {sig[30:0],1'b0} ^ (sig[31] ? MISR_POLY : 0) ^ {30'b0, right_out, left_out}`.
  - `MISR_POLY = 32'h04C1_1DB7`.
  - No other state modifies `signature`.
- Abort: `abort=1` in SEED, RUN or DONE forces IDLE on the next edge and pulses `aborted` in that IDLE cycle.
  - `done` does not pulse for a run aborted in SEED or RUN.
  - Abort in DONE: `done` has already pulsed this cycle, and `aborted` still pulses next cycle.
  - The signature is left as it was, partial.
- `start` while `busy` is ignored; it is not queued.
- `abort` in IDLE is ignored. `start` and `abort` together in IDLE: the start is accepted.
- `run_len` changes after acceptance have no effect on the current run.
- Counters: a seed counter of 8 bits and a run counter of `LEN_W` bits. Counting never wraps; `run_len` = 2^LEN_W−1 is legal.

## Timing
- Reset values: state IDLE; `cloud_en`, `cloud_seed`, `busy`, `done`, `aborted` all 0; `signature` 0; counters 0.
- All outputs are registered (Moore); no combinational path from input to output.
- With `start` sampled at edge 0:
  - SEED occupies cycles 1..`SEED_CYCLES`.
  - RUN occupies the next `run_len` cycles.
  - `done` is high in cycle `SEED_CYCLES+run_len+1`.
  - `busy` is high from cycle 1 through the DONE cycle.
  - The earliest next start is accepted on the edge ending the first IDLE cycle after DONE.
- The edge ending RUN cycle k samples `left_out`/`right_out` as presented during that cycle. Cloud pipeline latency is not compensated here.
- Reset asserted mid-run returns to IDLE immediately. The clouds see `cloud_en=0` asynchronously; no `done` or `aborted` pulse is produced.

## Structure
- Package `cloud_ctrl_pkg`:
  - state enum (IDLE, SEED, RUN, DONE);
  - `MISR_POLY`, `SIG_INIT`, `SIG_W=32`.
- Sub-module `misr32`, instantiated once: ports `clk`, `rst_n`, `clr`, `en`, `din[1:0]`, `sig[31:0]`.
- FSM and counters live in `cloud_run_ctrl`.

## Test plan
- Reset: hold `rst_n=0` mid-SEED → all outputs 0, state IDLE; release, idle 5 cycles → no output activity.
- Nominal run, `run_len=10`, `start` at edge 0 → `cloud_seed` high cycles 1–4; `cloud_en` high cycles 1–14; `done` pulses only in cycle 15; `busy` low in cycle 16.
- MISR values:
  - `run_len=1`, `left_out=1`, `right_out=0` → `signature=32'h0000_0001`.
  - `run_len=2`, same inputs → `32'h0000_0003`.
  - `run_len=40` with random inputs → matches bench reference model.
- `run_len=0` → SEED 4 cycles, `done` in cycle 5, signature stays 0.
- Abort in RUN cycle 3 → IDLE next cycle, `aborted` pulses once, no `done`, `cloud_en` 0; a restart right after completes normally.
- Protocol edges:
  - `start` pulses during RUN are ignored, and the run length is unchanged.
  - `start`+`abort` together in IDLE → run accepted.
  - `run_len` changed mid-run has no effect.
